// File: rtl/er_exec_monitor.sv
// ---------------------------------------------------------------------------
// er_exec_monitor
//
// Watches the CPU program counter around an executable region (ER) and
// produces a proof that the most recent run through the region was legal:
// entered only at ER_min, left only from ER_max, no interrupt taken and the
// exec flag from the memory-protection stage held the whole time. Any
// violation raises a sticky fault until the next legal entry or a software
// clear.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   pc         in   [15:0] current CPU program counter
//   exec       in   1 = IVT untouched since ER entry
//   irq        in   CPU interrupt-taken indication
//   ER_min     in   [15:0] first instruction address of the ER
//   ER_max     in   [15:0] last instruction address of the ER
//   clr        in   single-cycle request to discard a completed proof
//   proof      out  registered, 1 while state is DONE
//   fault      out  registered, 1 while state is FAULT
//   state_o    out  [1:0] registered state (00 IDLE, 01 RUN, 10 DONE, 11 FAULT)
//   run_count  out  [7:0] registered saturating count of legal completions
// ---------------------------------------------------------------------------
module er_exec_monitor (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        exec,
    input  logic        irq,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    input  logic        clr,
    output logic        proof,
    output logic        fault,
    output logic [1:0]  state_o,
    output logic [7:0]  run_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DONE  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] prev_pc_r;
    logic        in_er_s;
    logic        at_min_s;
    logic        complete_s;

    // Region decode and next-state selection.
    always_comb begin
        in_er_s    = (pc >= ER_min) && (pc <= ER_max);
        at_min_s   = (pc == ER_min);
        state_s    = state_r;
        complete_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                // Entry at ER_min is only legal with exec set; any other
                // landing inside the region is a mid-region entry.
                if (at_min_s && exec) begin
                    state_s = S_RUN;
                end else if (in_er_s) begin
                    state_s = S_FAULT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (!exec) begin
                    state_s = S_FAULT;
                end else if (irq) begin
                    state_s = S_FAULT;
                end else if (!in_er_s) begin
                    // The only legal exit is from the last instruction.
                    if (prev_pc_r == ER_max) begin
                        state_s    = S_DONE;
                        complete_s = 1'b1;
                    end else begin
                        state_s = S_FAULT;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE: begin
                // Re-entry wins over clr so back-to-back runs are not lost.
                if (!exec) begin
                    state_s = S_IDLE;
                end else if (at_min_s) begin
                    state_s = S_RUN;
                end else if (clr) begin
                    state_s = S_IDLE;
                end else if (in_er_s) begin
                    state_s = S_FAULT;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_FAULT: begin
                if (at_min_s && exec) begin
                    state_s = S_RUN;
                end else if (clr && !in_er_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_FAULT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, previous pc, status flags and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            prev_pc_r <= 16'h0000;
            proof     <= 1'b0;
            fault     <= 1'b0;
            run_count <= 8'h00;
        end else begin
            state_r   <= state_s;
            prev_pc_r <= pc;
            // Flags follow the next state, so a RUN entry clears both.
            proof     <= (state_s == S_DONE);
            fault     <= (state_s == S_FAULT);
            if (complete_s && (run_count != 8'hFF)) begin
                run_count <= run_count + 8'd1;
            end else begin
                run_count <= run_count;
            end
        end
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_er_exec_monitor.sv
// ---------------------------------------------------------------------------
// tb_er_exec_monitor
//
// Directed stimulus with hand-computed expected state and run_count. Each
// stimulus step queues the outputs expected after the next rising edge; a
// separate monitor samples on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_er_exec_monitor;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        exec;
    logic        irq;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        clr;
    logic        proof;
    logic        fault;
    logic [1:0]  state_o;
    logic [7:0]  run_count;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] id;
        logic [1:0]  st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    int   cnt_e = 0;

    er_exec_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .exec      (exec),
        .irq       (irq),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .clr       (clr),
        .proof     (proof),
        .fault     (fault),
        .state_o   (state_o),
        .run_count (run_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [15:0] p, input logic e, input logic i,
                        input logic c, input logic r, input logic [1:0] es);
        exp_t x;
        @(posedge clk);
        #1;
        pc    = p;
        exec  = e;
        irq   = i;
        clr   = c;
        reset = r;
        step_id = step_id + 1;
        x.due = cyc + 1;
        x.id  = step_id;
        x.st  = es;
        x.cnt = cnt_e[7:0];
        q.push_back(x);
    endtask

    task automatic legal_run();
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE0FF, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        cnt_e = (cnt_e >= 255) ? 255 : cnt_e + 1;
        step(16'h4100, 1'b1, 1'b0, 1'b0, 1'b0, DONE);
    endtask

    // Monitor: compare every queued expectation that falls due this cycle.
    initial begin
        exp_t x;
        logic ep;
        logic ef;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                x = q.pop_front();
                ep = (x.st == DONE);
                ef = (x.st == FAULT);
                checks = checks + 1;
                if (x.due != cyc || state_o !== x.st || proof !== ep ||
                    fault !== ef || run_count !== x.cnt) begin
                    errors = errors + 1;
                    $display("FAIL step%0d: got state=%0d proof=%0b fault=%0b run_count=%0d, expected state=%0d proof=%0b fault=%0b run_count=%0d",
                             x.id, state_o, proof, fault, run_count, x.st, ep, ef, x.cnt);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        pc     = 16'h0000;
        exec   = 1'b1;
        irq    = 1'b0;
        clr    = 1'b0;
        ER_min = 16'hE000;
        ER_max = 16'hE0FF;

        // Reset state.
        step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, IDLE);
        step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, IDLE);

        // Legal run, with intermediate pcs inside the ER.
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, IDLE);
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE080, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE0FF, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        cnt_e = 1;
        step(16'h4100, 1'b1, 1'b0, 1'b0, 1'b0, DONE);
        step(16'h4100, 1'b1, 1'b1, 1'b0, 1'b0, DONE);   // irq ignored in DONE
        step(16'h4200, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);   // clr discards proof

        // exec drop mid-run.
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE010, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE010, 1'b0, 1'b0, 1'b0, 1'b0, FAULT);
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, FAULT);  // sticky
        step(16'hE020, 1'b1, 1'b0, 1'b1, 1'b0, FAULT);  // clr inside ER ignored
        step(16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);

        // Mid-region entry, then recovery by legal entry.
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, IDLE);
        step(16'hE020, 1'b1, 1'b0, 1'b0, 1'b0, FAULT);
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);

        // irq in RUN, then illegal exit from a non-final address.
        step(16'hE050, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE050, 1'b1, 1'b1, 1'b0, 1'b0, FAULT);
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE050, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, FAULT);
        step(16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);

        // irq ignored in IDLE; entry without exec faults.
        step(16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, IDLE);
        step(16'hE000, 1'b0, 1'b0, 1'b0, 1'b0, FAULT);
        step(16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);

        // Re-entry beats clr in DONE; in-ER non-entry from DONE faults.
        legal_run();                                     // count 2
        step(16'hE000, 1'b1, 1'b0, 1'b1, 1'b0, RUN);
        step(16'hE0FF, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        cnt_e = 3;
        step(16'h4100, 1'b1, 1'b0, 1'b0, 1'b0, DONE);
        step(16'hE005, 1'b1, 1'b0, 1'b0, 1'b0, FAULT);
        legal_run();                                     // count 4
        step(16'h4100, 1'b0, 1'b0, 1'b0, 1'b0, IDLE);   // exec low in DONE

        // Single-instruction ER.
        ER_min = 16'h1234;
        ER_max = 16'h1234;
        step(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        cnt_e = 5;
        step(16'h2000, 1'b1, 1'b0, 1'b0, 1'b0, DONE);
        step(16'h2000, 1'b1, 1'b0, 1'b1, 1'b0, IDLE);
        ER_min = 16'hE000;
        ER_max = 16'hE0FF;

        // Saturation: reset, then 256 legal runs.
        cnt_e = 0;
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b1, IDLE);
        for (int n = 0; n < 256; n++) begin
            legal_run();
        end

        // Reset mid-run aborts everything; reset beats a legal entry.
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        step(16'hE010, 1'b1, 1'b0, 1'b0, 1'b0, RUN);
        cnt_e = 0;
        step(16'hE010, 1'b1, 1'b0, 1'b0, 1'b1, IDLE);
        step(16'hE000, 1'b1, 1'b0, 1'b0, 1'b1, IDLE);
        step(16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, IDLE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/er_exec_monitor.md
ER_EXEC_MONITOR -- requirements
Module: er_exec_monitor

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port pc, input, 16, current CPU program counter.
REQ-004 SHALL have port exec, input, 1, execution-validity flag from the memory-protection stage; 1 = IVT untouched since ER entry.
REQ-005 SHALL have port irq, input, 1, CPU interrupt-taken indication.
REQ-006 SHALL have ports ER_min and ER_max, input, 16 each, first and last instruction address of the executable region (ER); static while monitored.
REQ-007 SHALL have port clr, input, 1, single-cycle software request to discard a completed proof.
REQ-008 SHALL have port proof, output, 1, registered; 1 = last ER run completed legally with exec held.
REQ-009 SHALL have port fault, output, 1, registered sticky; 1 = last ER run violated entry/exit/interrupt/exec rules.
REQ-010 SHALL have port state_o, output, 2, registered FSM state (00 IDLE, 01 RUN, 10 DONE, 11 FAULT).
REQ-011 SHALL have port run_count, output, 8, registered count of legal completions, saturating.

Function
REQ-012 SHALL keep a registered copy prev_pc of pc from the previous cycle; in_er = (pc >= ER_min && pc <= ER_max), unsigned 16-bit compares.
REQ-013 IDLE: pc == ER_min && exec -> RUN; in_er && pc != ER_min -> FAULT (mid-region entry); pc == ER_min && !exec -> FAULT; else stay.
REQ-014 RUN: priority order (a) !exec -> FAULT, (b) irq -> FAULT, (c) !in_er && prev_pc == ER_max -> DONE, (d) !in_er && prev_pc != ER_max -> FAULT, (e) else stay.
REQ-015 DONE: !exec -> IDLE; else pc == ER_min -> RUN; else clr -> IDLE; else in_er -> FAULT; else stay. Entry at ER_min SHALL take priority over clr in the same cycle.
REQ-016 FAULT: pc == ER_min && exec -> RUN; else clr && !in_er -> IDLE; else stay.
REQ-017 proof SHALL be 1 exactly while state is DONE, asserting the cycle after the exit edge (one-cycle latency from the first out-of-ER pc).
REQ-018 fault SHALL be 1 exactly while state is FAULT.
REQ-019 Every RUN entry SHALL clear proof and fault in the same clock edge the state becomes RUN.
REQ-020 run_count SHALL increment by 1 on each RUN->DONE transition and saturate at 8'hFF (no wrap).
REQ-021 ER_min == ER_max (single-instruction ER) SHALL be legal: entry and exit both reference the same address.
REQ-022 irq in any state other than RUN SHALL have no effect.

Reset
REQ-023 reset SHALL force state IDLE, proof 0, fault 0, run_count 8'h00, prev_pc 16'h0000 on the next rising clk, overriding all other inputs.
REQ-024 reset asserted during RUN SHALL abort the run with no DONE, no FAULT, no count change.

Verification
REQ-025 ER=0xE000..0xE0FF, exec=1: pc 0x4000 -> 0xE000 -> ... -> 0xE0FF -> 0x4100 -> state DONE, proof=1 one cycle after 0x4100, run_count=1.
REQ-026 Same ER, exec drops to 0 while pc=0xE010 -> FAULT next cycle, fault=1, proof=0, run_count unchanged.
REQ-027 pc jumps 0x4000 -> 0xE020 -> FAULT; then pc 0xE000 with exec=1 -> RUN, fault=0.
REQ-028 In RUN at pc 0xE050, irq=1 -> FAULT; exit from 0xE050 to 0x4000 without irq also -> FAULT.
REQ-029 In DONE, pulse clr with pc=0x4200 -> IDLE, proof=0; clr and pc=0xE000 same cycle -> RUN.
REQ-030 Force 255 legal runs then a 256th -> run_count stays 8'hFF; reset mid-run -> all outputs zero next cycle.
